ni_gen2: RTL and testbench
==========================

NI_GEN2 -- requirements
Module: ni_gen2

Interface
REQ-001 The block SHALL provide parameter GPU_ID, default 17, this node's GPU identifier (1..NUM_GPUS).
REQ-002 The block SHALL provide parameter NUM_GPUS, default 32, the number of valid GPU identifiers (1..NUM_GPUS).
REQ-003 The block SHALL provide parameter DATA_W, default 16, the flit width.
REQ-004 The block SHALL provide parameter HDR_W, default 6, the header width (GPU ID on GPU side, routing address on router side); payload width is DATA_W-HDR_W.
REQ-005 The block SHALL provide parameter ADDR_OFFSET, default 3, where routing address = GPU ID + ADDR_OFFSET.
REQ-006 The block SHALL provide parameter FIFO_DEPTH, default 8, a power of two >= 2, the entry count of each FIFO.
REQ-007 Ports (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  reset  in  1  synchronous, active-high.
  gpu_data_in  in  DATA_W  [DATA_W-1 -: HDR_W] = destination GPU ID, rest = payload.
  gpu_valid_in  in  1  GPU offers a flit.
  gpu_ready_out  out  1  TX FIFO can accept.
  router_data_out  out  DATA_W  translated flit to router.
  router_valid_out  out  1  flit offered to router.
  router_ready_in  in  1  router accepts.
  router_data_in  in  DATA_W  flit from router, header = routing address.
  router_valid_in  in  1  router offers a flit.
  router_ready_out  out  1  RX FIFO can accept.
  gpu_data_out  out  DATA_W  delivered flit, header = source-format GPU ID.
  gpu_valid_out  out  1  flit offered to GPU.
  gpu_ready_in  in  1  GPU accepts.
  tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1  occupancy of each FIFO.
  tx_drop_cnt, rx_drop_cnt  out  8  saturating drop counters.

Function
REQ-008 A transfer SHALL occur on an interface only in a cycle where valid and ready are both high at the rising edge of clk.
REQ-009 gpu_ready_out SHALL equal (tx_level != FIFO_DEPTH) and router_ready_out SHALL equal (rx_level != FIFO_DEPTH), with no combinational dependence on any input.
REQ-010 On a GPU-side transfer with destination ID in 1..NUM_GPUS, the TX FIFO SHALL store {ID+ADDR_OFFSET (HDR_W bits), payload}.
REQ-011 On a GPU-side transfer with ID 0 or > NUM_GPUS, the flit SHALL be accepted and discarded, with tx_drop_cnt incremented.
REQ-012 router_valid_out SHALL equal (tx_level != 0), and router_data_out SHALL equal the head entry; both SHALL be register-driven.
REQ-013 A held router_valid_out with router_ready_in low SHALL keep router_data_out stable until the transfer occurs.
REQ-014 Latency SHALL be one cycle: a flit written at edge k SHALL be visible on router_valid_out/router_data_out after edge k when the FIFO was empty.
REQ-015 On a router-side transfer, a flit with header == GPU_ID+ADDR_OFFSET SHALL be stored in the RX FIFO as {GPU_ID, payload}.
REQ-016 On a router-side transfer with any other header, the flit SHALL be accepted and discarded, with rx_drop_cnt incremented.
REQ-017 gpu_valid_out and gpu_data_out SHALL follow the RX FIFO head with the rules of REQ-012..REQ-014.
REQ-018 A simultaneous push and pop on one FIFO SHALL leave its level unchanged, including when the FIFO is full (pop frees the slot) and when it is empty (push lands, no pop occurs).
REQ-019 Pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; levels SHALL never exceed FIFO_DEPTH or underflow.
REQ-020 A dropped flit SHALL not change the FIFO level; drop counters SHALL saturate at 255.
REQ-021 The TX and RX paths SHALL be fully independent; any combination of simultaneous events on both paths SHALL be handled in the same cycle.

Reset
REQ-022 While reset is high at a clock edge, the block SHALL clear all pointers, levels and drop counters, drive router_valid_out, gpu_valid_out, router_data_out and gpu_data_out to 0, and drive gpu_ready_out and router_ready_out to 1 from the following cycle.
REQ-023 A reset asserted mid-operation SHALL flush both FIFOs; no pre-reset flit SHALL appear after reset.
REQ-024 FIFO storage contents SHALL need no reset.

Verification
REQ-025 GPU sends 0x0805 (ID 2) with router_ready_in=1 -> router_valid_out high next cycle, data 0x1405; tx_level returns to 0.
REQ-026 router_ready_in=0, 9 GPU flits offered back-to-back -> gpu_ready_out low after 8, tx_level=8, 9th not accepted; release ready -> 8 flits out in order, one per cycle.
REQ-027 Full TX FIFO with simultaneous push and pop -> tx_level stays 8, order preserved across pointer wrap.
REQ-028 Router delivers 0x5003 (addr 20 = own) -> gpu_data_out 0x4403; router delivers 0x5403 -> discarded, rx_drop_cnt=1, rx_level unchanged.
REQ-029 GPU flits with ID 0 and ID 40 -> both dropped, tx_drop_cnt=2; 300 bad flits -> counter holds 255.
REQ-030 Reset asserted with both FIFOs half full -> next cycle levels=0, valids=0, readies=1; no stale flit emitted.

Source files
------------

// File: rtl/ni_gen2.sv
// GPU network interface: translates GPU IDs to routing addresses on the TX path and filters
// and translates router flits back to this node's ID on the RX path.

module ni_gen2_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       head_valid,
  output logic [DATA_W-1:0]          head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [LVL_W-1:0]  level_next;
  logic [DATA_W-1:0] head_next;
  logic              do_push;
  logic              do_pop;

  // The head register is preloaded with the entry that will be at the read pointer after this
  // edge; a push into the slot that becomes the head is bypassed so latency stays one cycle.
  always_comb begin
    do_pop      = pop && (level != '0);
    do_push     = push && ((level != FULL) || do_pop);
    rd_ptr_next = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_next  = level;
    if (do_push && !do_pop)
      level_next = level + LVL_W'(1);
    else if (do_pop && !do_push)
      level_next = level - LVL_W'(1);
    head_next = '0;
    if (level_next != '0) begin
      if (do_push && (rd_ptr_next == wr_ptr))
        head_next = push_data;
      else
        head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_ptr_next;
      level      <= level_next;
      head_valid <= (level_next != '0);
      head_data  <= head_next;
    end
  end
endmodule

module ni_gen2 #(
  parameter int GPU_ID      = 17,
  parameter int NUM_GPUS    = 32,
  parameter int DATA_W      = 16,
  parameter int HDR_W       = 6,
  parameter int ADDR_OFFSET = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             gpu_data_in,
  input  logic                          gpu_valid_in,
  output logic                          gpu_ready_out,
  output logic [DATA_W-1:0]             router_data_out,
  output logic                          router_valid_out,
  input  logic                          router_ready_in,
  input  logic [DATA_W-1:0]             router_data_in,
  input  logic                          router_valid_in,
  output logic                          router_ready_out,
  output logic [DATA_W-1:0]             gpu_data_out,
  output logic                          gpu_valid_out,
  input  logic                          gpu_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [7:0]                    tx_drop_cnt,
  output logic [7:0]                    rx_drop_cnt
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PAY_W = DATA_W - HDR_W;
  localparam logic [LVL_W-1:0] FULL     = LVL_W'(FIFO_DEPTH);
  localparam logic [HDR_W:0]   MAX_ID   = (HDR_W+1)'(NUM_GPUS);
  localparam logic [HDR_W-1:0] OFFSET   = HDR_W'(ADDR_OFFSET);
  localparam logic [HDR_W-1:0] OWN_ID   = HDR_W'(GPU_ID);
  localparam logic [HDR_W-1:0] OWN_ADDR = HDR_W'(GPU_ID + ADDR_OFFSET);

  logic [HDR_W-1:0]  tx_id;
  logic [PAY_W-1:0]  tx_payload;
  logic [HDR_W-1:0]  rx_addr;
  logic [PAY_W-1:0]  rx_payload;
  logic              tx_accept;
  logic              tx_id_ok;
  logic              tx_push;
  logic              tx_drop;
  logic              tx_pop;
  logic              rx_accept;
  logic              rx_push;
  logic              rx_drop;
  logic              rx_pop;
  logic [DATA_W-1:0] tx_entry;
  logic [DATA_W-1:0] rx_entry;

  // Readiness depends only on registered levels, never on the opposite side's handshake.
  assign gpu_ready_out    = (tx_level != FULL);
  assign router_ready_out = (rx_level != FULL);

  always_comb begin
    tx_id      = gpu_data_in[DATA_W-1 -: HDR_W];
    tx_payload = gpu_data_in[PAY_W-1:0];
    rx_addr    = router_data_in[DATA_W-1 -: HDR_W];
    rx_payload = router_data_in[PAY_W-1:0];

    tx_accept = gpu_valid_in && gpu_ready_out;
    tx_id_ok  = (tx_id != '0) && ({1'b0, tx_id} <= MAX_ID);
    tx_push   = tx_accept && tx_id_ok;
    tx_drop   = tx_accept && !tx_id_ok;
    tx_pop    = router_valid_out && router_ready_in;
    tx_entry  = {tx_id + OFFSET, tx_payload};

    rx_accept = router_valid_in && router_ready_out;
    rx_push   = rx_accept && (rx_addr == OWN_ADDR);
    rx_drop   = rx_accept && (rx_addr != OWN_ADDR);
    rx_pop    = gpu_valid_out && gpu_ready_in;
    rx_entry  = {OWN_ID, rx_payload};
  end

  ni_gen2_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (tx_push),
    .push_data  (tx_entry),
    .pop        (tx_pop),
    .level      (tx_level),
    .head_valid (router_valid_out),
    .head_data  (router_data_out)
  );

  ni_gen2_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rx_push),
    .push_data  (rx_entry),
    .pop        (rx_pop),
    .level      (rx_level),
    .head_valid (gpu_valid_out),
    .head_data  (gpu_data_out)
  );

  // Drop counters stick at 255 rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop_cnt <= '0;
      rx_drop_cnt <= '0;
    end else begin
      if (tx_drop && (tx_drop_cnt != 8'hFF))
        tx_drop_cnt <= tx_drop_cnt + 8'd1;
      if (rx_drop && (rx_drop_cnt != 8'hFF))
        rx_drop_cnt <= rx_drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_ni_gen2.sv
// Directed self-checking bench for ni_gen2 with default parameters (GPU 17, offset 3, depth 8).

module tb_ni_gen2;
  logic        clk;
  logic        reset;
  logic [15:0] gpu_data_in;
  logic        gpu_valid_in;
  logic        gpu_ready_out;
  logic [15:0] router_data_out;
  logic        router_valid_out;
  logic        router_ready_in;
  logic [15:0] router_data_in;
  logic        router_valid_in;
  logic        router_ready_out;
  logic [15:0] gpu_data_out;
  logic        gpu_valid_out;
  logic        gpu_ready_in;
  logic [3:0]  tx_level;
  logic [3:0]  rx_level;
  logic [7:0]  tx_drop_cnt;
  logic [7:0]  rx_drop_cnt;

  int checks = 0;
  int errors = 0;

  ni_gen2 dut (
    .clk              (clk),
    .reset            (reset),
    .gpu_data_in      (gpu_data_in),
    .gpu_valid_in     (gpu_valid_in),
    .gpu_ready_out    (gpu_ready_out),
    .router_data_out  (router_data_out),
    .router_valid_out (router_valid_out),
    .router_ready_in  (router_ready_in),
    .router_data_in   (router_data_in),
    .router_valid_in  (router_valid_in),
    .router_ready_out (router_ready_out),
    .gpu_data_out     (gpu_data_out),
    .gpu_valid_out    (gpu_valid_out),
    .gpu_ready_in     (gpu_ready_in),
    .tx_level         (tx_level),
    .rx_level         (rx_level),
    .tx_drop_cnt      (tx_drop_cnt),
    .rx_drop_cnt      (rx_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (tx_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_tx_level got %0d want 0", tx_level); end
    checks++; if (rx_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_rx_level got %0d want 0", rx_level); end
    checks++; if (router_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_router_valid got %b want 0", router_valid_out); end
    checks++; if (gpu_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_gpu_valid got %b want 0", gpu_valid_out); end
    checks++; if (router_data_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_router_data got %h want 0000", router_data_out); end
    checks++; if (gpu_data_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_gpu_data got %h want 0000", gpu_data_out); end
    checks++; if (gpu_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_gpu_ready got %b want 1", gpu_ready_out); end
    checks++; if (router_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_router_ready got %b want 1", router_ready_out); end
    checks++; if (tx_drop_cnt !== 8'd0 || rx_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt got %0d/%0d want 0/0", tx_drop_cnt, rx_drop_cnt); end
  endtask

  task automatic test_basic_tx();
    router_ready_in = 1'b1;
    gpu_data_in     = 16'h0805;
    gpu_valid_in    = 1'b1;
    step();
    gpu_valid_in = 1'b0;
    checks++; if (router_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b want 1", router_valid_out); end
    checks++; if (router_data_out !== 16'h1405) begin errors++; $display("[TB] FAIL basic_data got %h want 1405", router_data_out); end
    checks++; if (tx_level !== 4'd1) begin errors++; $display("[TB] FAIL basic_level got %0d want 1", tx_level); end
    step();
    checks++; if (tx_level !== 4'd0) begin errors++; $display("[TB] FAIL basic_drain_level got %0d want 0", tx_level); end
    checks++; if (router_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain_valid got %b want 0", router_valid_out); end
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp;
    router_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      // ID i+1, payload 0x100+i; the ninth offer must meet a deasserted ready.
      gpu_data_in  = 16'(((i + 1) << 10) | (16'h100 + i));
      gpu_valid_in = 1'b1;
      if (i == 8) begin
        checks++; if (gpu_ready_out !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready_at_full got %b want 0", gpu_ready_out); end
      end
      step();
    end
    gpu_valid_in = 1'b0;
    checks++; if (tx_level !== 4'd8) begin errors++; $display("[TB] FAIL fill_level got %0d want 8", tx_level); end
    step();
    step();
    checks++; if (router_data_out !== 16'h1100) begin errors++; $display("[TB] FAIL stall_data_stable got %h want 1100", router_data_out); end
    router_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp = 16'(((k + 4) << 10) | (16'h100 + k));
      checks++; if (router_valid_out !== 1'b1 || router_data_out !== exp) begin errors++; $display("[TB] FAIL drain_%0d got %b/%h want 1/%h", k, router_valid_out, router_data_out, exp); end
      step();
    end
    checks++; if (tx_level !== 4'd0 || router_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got %0d/%b want 0/0", tx_level, router_valid_out); end
  endtask

  task automatic test_steady_push_pop();
    logic [15:0] seq [17];
    // A flits use ID 5 (addr 8), B flits ID 6 (addr 9).
    for (int i = 0; i < 7; i++) seq[i] = 16'((8 << 10) | (i + 1));
    for (int j = 0; j < 10; j++) seq[7 + j] = 16'((9 << 10) | (16'h200 + j));
    router_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gpu_data_in  = 16'((5 << 10) | i);
      gpu_valid_in = 1'b1;
      step();
    end
    gpu_valid_in    = 1'b0;
    router_ready_in = 1'b1;
    step();
    checks++; if (tx_level !== 4'd7) begin errors++; $display("[TB] FAIL pp_first_pop_level got %0d want 7", tx_level); end
    for (int j = 0; j < 10; j++) begin
      gpu_data_in  = 16'((6 << 10) | (16'h200 + j));
      gpu_valid_in = 1'b1;
      checks++; if (router_data_out !== seq[j] || gpu_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL pp_head_%0d got %h/%b want %h/1", j, router_data_out, gpu_ready_out, seq[j]); end
      step();
      checks++; if (tx_level !== 4'd7) begin errors++; $display("[TB] FAIL pp_level_%0d got %0d want 7", j, tx_level); end
    end
    gpu_valid_in = 1'b0;
    for (int j = 10; j < 17; j++) begin
      checks++; if (router_data_out !== seq[j]) begin errors++; $display("[TB] FAIL pp_tail_%0d got %h want %h", j, router_data_out, seq[j]); end
      step();
    end
    checks++; if (tx_level !== 4'd0) begin errors++; $display("[TB] FAIL pp_empty got %0d want 0", tx_level); end
  endtask

  task automatic test_rx_filter();
    gpu_ready_in    = 1'b0;
    router_data_in  = 16'h5003;
    router_valid_in = 1'b1;
    step();
    checks++; if (gpu_valid_out !== 1'b1 || gpu_data_out !== 16'h4403) begin errors++; $display("[TB] FAIL rx_own got %b/%h want 1/4403", gpu_valid_out, gpu_data_out); end
    router_data_in = 16'h5403;
    step();
    router_valid_in = 1'b0;
    checks++; if (rx_drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL rx_drop_cnt got %0d want 1", rx_drop_cnt); end
    checks++; if (rx_level !== 4'd1 || gpu_data_out !== 16'h4403) begin errors++; $display("[TB] FAIL rx_after_drop got %0d/%h want 1/4403", rx_level, gpu_data_out); end
    gpu_ready_in = 1'b1;
    step();
    checks++; if (rx_level !== 4'd0 || gpu_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rx_drain got %0d/%b want 0/0", rx_level, gpu_valid_out); end
  endtask

  task automatic test_tx_drops();
    router_ready_in = 1'b1;
    gpu_valid_in    = 1'b1;
    gpu_data_in     = 16'h0011;
    step();
    gpu_data_in = 16'hA011;
    step();
    gpu_valid_in = 1'b0;
    checks++; if (tx_drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL tx_drop_two got %0d want 2", tx_drop_cnt); end
    checks++; if (tx_level !== 4'd0 || router_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL tx_drop_no_push got %0d/%b want 0/0", tx_level, router_valid_out); end
    gpu_valid_in = 1'b1;
    gpu_data_in  = 16'h0001;
    for (int i = 0; i < 300; i++) step();
    gpu_valid_in = 1'b0;
    checks++; if (tx_drop_cnt !== 8'd255) begin errors++; $display("[TB] FAIL tx_drop_saturate got %0d want 255", tx_drop_cnt); end
  endtask

  task automatic test_concurrent();
    router_ready_in = 1'b0;
    gpu_ready_in    = 1'b0;
    gpu_data_in     = 16'h0805;
    gpu_valid_in    = 1'b1;
    router_data_in  = 16'h5003;
    router_valid_in = 1'b1;
    step();
    checks++; if (tx_level !== 4'd1 || router_data_out !== 16'h1405) begin errors++; $display("[TB] FAIL conc_tx got %0d/%h want 1/1405", tx_level, router_data_out); end
    checks++; if (rx_level !== 4'd1 || gpu_data_out !== 16'h4403) begin errors++; $display("[TB] FAIL conc_rx got %0d/%h want 1/4403", rx_level, gpu_data_out); end
    router_ready_in = 1'b1;
    gpu_ready_in    = 1'b1;
    gpu_data_in     = 16'h0C07;
    router_data_in  = 16'h500A;
    step();
    gpu_valid_in    = 1'b0;
    router_valid_in = 1'b0;
    checks++; if (tx_level !== 4'd1 || router_data_out !== 16'h1807) begin errors++; $display("[TB] FAIL conc_tx_pp got %0d/%h want 1/1807", tx_level, router_data_out); end
    checks++; if (rx_level !== 4'd1 || gpu_data_out !== 16'h440A) begin errors++; $display("[TB] FAIL conc_rx_pp got %0d/%h want 1/440a", rx_level, gpu_data_out); end
    step();
    checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin errors++; $display("[TB] FAIL conc_empty got %0d/%0d want 0/0", tx_level, rx_level); end
  endtask

  task automatic test_reset_flush();
    router_ready_in = 1'b0;
    gpu_ready_in    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gpu_data_in     = 16'((2 << 10) | (16'h30 + i));
      gpu_valid_in    = 1'b1;
      router_data_in  = 16'((20 << 10) | (16'h40 + i));
      router_valid_in = 1'b1;
      step();
    end
    gpu_valid_in    = 1'b0;
    router_valid_in = 1'b0;
    checks++; if (tx_level !== 4'd4 || rx_level !== 4'd4) begin errors++; $display("[TB] FAIL flush_pre_levels got %0d/%0d want 4/4", tx_level, rx_level); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (tx_level !== 4'd0 || rx_level !== 4'd0) begin errors++; $display("[TB] FAIL flush_levels got %0d/%0d want 0/0", tx_level, rx_level); end
    checks++; if (router_valid_out !== 1'b0 || gpu_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL flush_valids got %b/%b want 0/0", router_valid_out, gpu_valid_out); end
    checks++; if (gpu_ready_out !== 1'b1 || router_ready_out !== 1'b1) begin errors++; $display("[TB] FAIL flush_readies got %b/%b want 1/1", gpu_ready_out, router_ready_out); end
    checks++; if (tx_drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL flush_drop_cnt got %0d want 0", tx_drop_cnt); end
    router_ready_in = 1'b1;
    gpu_ready_in    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (router_valid_out !== 1'b0 || gpu_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL flush_stale_%0d got %b/%b want 0/0", i, router_valid_out, gpu_valid_out); end
    end
  endtask

  initial begin
    reset           = 1'b1;
    gpu_data_in     = '0;
    gpu_valid_in    = 1'b0;
    router_ready_in = 1'b0;
    router_data_in  = '0;
    router_valid_in = 1'b0;
    gpu_ready_in    = 1'b0;
    test_reset();
    test_basic_tx();
    test_fill_drain();
    test_steady_push_pop();
    test_rx_filter();
    test_tx_drops();
    test_concurrent();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
